// File: rtl/ta_cap_buf.sv
// Pre/post-trigger capture buffer: keeps a circular history while armed, fills the
// post-trigger window, then streams pre+post words out over valid/ready.
module ta_cap_buf #(
  parameter int ADC0_1 = 56,
  parameter int ADDR_W = 10
) (
  input  logic              clk62,
  input  logic              rst,
  input  logic [ADC0_1-1:0] merge_data,
  input  logic              mereg_datv,
  input  logic              mem_reset,
  input  logic              cap_arm,
  input  logic              cap_trig,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  output logic [ADC0_1-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              cap_busy,
  output logic              cap_done,
  output logic [ADDR_W-1:0] trig_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ} state_t;
  state_t state, state_nxt;

  logic [ADC0_1-1:0] mem [DEPTH];
  logic [ADC0_1-1:0] data_p1;
  logic              vld_p1, last_p1;
  logic [ADDR_W-1:0] pre_q, post_q, pre_cnt, post_cnt, wr_ptr, rd_addr;
  logic [ADDR_W:0]   rd_len, issue_cnt;
  logic              wr_en, rd_en, adv;

  // Zero post length means "trigger word only"; the window never exceeds the RAM.
  function automatic logic [ADDR_W-1:0] clamp_post(input logic [ADDR_W-1:0] pre,
                                                   input logic [ADDR_W-1:0] post);
    logic [ADDR_W:0] eff;
    logic [ADDR_W:0] room;
    eff  = (post == '0) ? (ADDR_W+1)'(1) : {1'b0, post};
    room = (ADDR_W+1)'(DEPTH) - {1'b0, pre};
    return (eff > room) ? room[ADDR_W-1:0] : eff[ADDR_W-1:0];
  endfunction

  assign cap_busy = (state != IDLE);
  assign wr_en    = !mem_reset && mereg_datv && (state inside {PRE, WAIT_TRIG, POST});
  assign adv      = !rd_valid || rd_ready;
  assign rd_en    = !mem_reset && (state == READ) && (issue_cnt != rd_len) && adv;

  always_ff @(posedge clk62 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (cap_arm) state_nxt = (pre_len == '0) ? WAIT_TRIG : PRE;
      PRE:       if (mereg_datv && (pre_cnt + ADDR_W'(1)) == pre_q) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (cap_trig) state_nxt = POST;
      POST:      if (mereg_datv && (post_cnt + ADDR_W'(1)) == post_q) state_nxt = READ;
      READ:      if (rd_valid && rd_ready && rd_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (mem_reset) state_nxt = IDLE;
  end

  // RAM: write port for capture, registered read port with enable so a stalled
  // output keeps the prefetched word in data_p1.
  always_ff @(posedge clk62) begin
    if (wr_en) mem[wr_ptr] <= merge_data;
    if (rd_en) data_p1 <= mem[rd_addr];
  end

  always_ff @(posedge clk62 or negedge rst) begin
    if (!rst) begin
      pre_q     <= '0;
      post_q    <= '0;
      rd_len    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      wr_ptr    <= '0;
      rd_addr   <= '0;
      issue_cnt <= '0;
      trig_addr <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      cap_done  <= 1'b0;
    end else if (mem_reset) begin
      pre_cnt   <= '0;
      post_cnt  <= '0;
      wr_ptr    <= '0;
      rd_addr   <= '0;
      issue_cnt <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      cap_done  <= 1'b0;
    end else begin
      cap_done <= (state == READ) && rd_valid && rd_ready && rd_last;
      if (state == IDLE && cap_arm) begin
        pre_q     <= pre_len;
        post_q    <= clamp_post(pre_len, post_len);
        rd_len    <= {1'b0, pre_len} + {1'b0, clamp_post(pre_len, post_len)};
        pre_cnt   <= '0;
        post_cnt  <= '0;
        wr_ptr    <= '0;
        issue_cnt <= '0;
      end
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (wr_en && state == PRE) pre_cnt <= pre_cnt + ADDR_W'(1);
      if (wr_en && state == POST) begin
        post_cnt <= post_cnt + ADDR_W'(1);
        if (post_cnt == '0) begin
          trig_addr <= wr_ptr;
          rd_addr   <= wr_ptr - pre_q;
        end
      end
      // Stage p1: RAM read issued, word lands in data_p1
      if (rd_en) begin
        rd_addr   <= rd_addr + ADDR_W'(1);
        issue_cnt <= issue_cnt + (ADDR_W+1)'(1);
        last_p1   <= (issue_cnt + (ADDR_W+1)'(1)) == rd_len;
      end
      if (adv) vld_p1 <= rd_en;
      // Stage p2: output register, advances only when empty or accepted
      if (adv) begin
        rd_valid <= vld_p1;
        rd_last  <= vld_p1 && last_p1;
        if (vld_p1) rd_data <= data_p1;
      end
    end
  end
endmodule

// File: tb/tb_ta_cap_buf.sv
// Bench for ta_cap_buf: a linear-history capture model checked every cycle,
// plus literal window expectations for each directed scenario.
module tb_ta_cap_buf;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  typedef logic [55:0] word_t;

  logic clk62, rst, mereg_datv, mem_reset, cap_arm, cap_trig, rd_ready;
  word_t merge_data, rd_data;
  logic [AW-1:0] pre_len, post_len, trig_addr;
  logic rd_valid, rd_last, cap_busy, cap_done;

  ta_cap_buf #(.ADC0_1(56), .ADDR_W(AW)) dut (
    .clk62(clk62), .rst(rst), .merge_data(merge_data), .mereg_datv(mereg_datv),
    .mem_reset(mem_reset), .cap_arm(cap_arm), .cap_trig(cap_trig),
    .pre_len(pre_len), .post_len(post_len), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .cap_busy(cap_busy), .cap_done(cap_done),
    .trig_addr(trig_addr)
  );

  initial clk62 = 1'b0;
  always #5 clk62 = ~clk62;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int val = 1;
  word_t got[$];

  always @(posedge clk62) cyc <= cyc + 1;

  function automatic word_t mk(int v);
    return {24'(v * 3), 32'(v)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: words written since arm kept as a plain list; window sliced out of it.
  word_t hist[$];
  word_t exp_q[$];
  word_t m_prev;
  bit m_armed, m_reading, m_trigd, m_done_due, m_must, m_stall, m_seen, tnow, was_armed;
  int m_pre, m_post, m_got_post, m_tpos, m_read_edge;
  logic [AW-1:0] m_trig;

  always @(negedge clk62) begin
    if (!rst) begin
      hist.delete(); exp_q.delete();
      m_armed = 0; m_reading = 0; m_trigd = 0; m_done_due = 0; m_must = 0;
      m_stall = 0; m_seen = 0; m_trig = '0; m_prev = '0;
    end else begin
      chk("cap_busy", cap_busy, m_armed);
      chk("cap_done", cap_done, m_done_due);
      chk("trig_addr", trig_addr, m_trig);
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", rd_valid, 0);
        else begin
          if (!m_seen) begin
            chk("first_latency", cyc - m_read_edge, 2);
            m_seen = 1;
          end
          chk("rd_data", rd_data, exp_q[0]);
          chk("rd_last", rd_last, exp_q.size() == 1);
        end
        if (m_stall) chk("stall_stable", rd_data, m_prev);
      end else begin
        if (m_must) chk("bubble", rd_valid, 1);
        if (m_stall) chk("stall_dropped", rd_valid, 1);
      end
      if (rd_valid && rd_ready) got.push_back(rd_data);

      was_armed = m_armed;
      m_done_due = 0;
      m_must = 0;
      m_stall = rd_valid && !rd_ready;
      m_prev = rd_data;
      if (rd_valid && rd_ready && exp_q.size() > 0 && !mem_reset) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_done_due = 1; m_armed = 0; m_reading = 0;
        end else m_must = 1;
      end
      if (mem_reset) begin
        m_armed = 0; m_reading = 0; m_trigd = 0; exp_q.delete();
        m_stall = 0; m_must = 0; m_done_due = 0;
      end else if (!was_armed) begin
        if (cap_arm) begin
          m_pre = int'(pre_len);
          m_post = (post_len == 0) ? 1 : int'(post_len);
          if (m_pre + m_post > DEPTH) m_post = DEPTH - m_pre;
          hist.delete();
          m_trigd = 0; m_got_post = 0; m_armed = 1; m_seen = 0;
        end
      end else if (!m_reading) begin
        tnow = !m_trigd && cap_trig && (hist.size() >= m_pre);
        if (mereg_datv) begin
          if (m_trigd) begin
            if (m_got_post == 0) begin
              m_tpos = hist.size();
              m_trig = AW'(m_tpos % DEPTH);
            end
            m_got_post++;
          end
          hist.push_back(merge_data);
          if (m_trigd && m_got_post == m_post) begin
            for (int i = m_tpos - m_pre; i < m_tpos + m_post; i++) exp_q.push_back(hist[i]);
            m_reading = 1;
            m_read_edge = cyc + 1;
          end
        end
        if (tnow) m_trigd = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk62);
    #1;
  endtask

  task automatic start(int pre, int post, int first);
    pre_len = AW'(pre);
    post_len = AW'(post);
    val = first;
    got.delete();
    cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
  endtask

  task automatic feed(int n);
    for (int i = 0; i < n; i++) begin
      merge_data = mk(val);
      mereg_datv = 1'b1;
      val++;
      tick();
    end
    mereg_datv = 1'b0;
  endtask

  task automatic trig();
    cap_trig = 1'b1;
    tick();
    cap_trig = 1'b0;
  endtask

  task automatic wait_done(bit rnd);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      tick();
      if (cap_done) seen = 1;
    end
    chk("done_seen", seen, 1);
    rd_ready = 1'b0;
    tick();
  endtask

  task automatic chk_window(string nm, int first, int n);
    chk({nm, "_count"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) chk({nm, "_word"}, got[i], mk(first + i));
  endtask

  initial begin
    rst = 1'b0; mereg_datv = 1'b0; mem_reset = 1'b0; cap_arm = 1'b0; cap_trig = 1'b0;
    rd_ready = 1'b0; merge_data = '0; pre_len = '0; post_len = '0;
    repeat (3) tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", cap_busy, 0);
    chk("rst_done", cap_done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    rst = 1'b1;
    tick();

    // Basic window: trigger word 11, window 7..14
    start(4, 4, 1); feed(10); trig(); feed(4);
    rd_ready = 1'b1; wait_done(0);
    chk_window("basic", 7, 8);
    chk("basic_trig_addr", trig_addr, 10);

    // Address wrap: trigger word 21 lands at address 4
    start(6, 6, 1); feed(20); trig(); feed(6);
    rd_ready = 1'b1; wait_done(0);
    chk_window("wrap", 15, 12);
    chk("wrap_trig_addr", trig_addr, 4);

    // Zero lengths: trigger word only
    start(0, 0, 1); feed(3); trig(); feed(1);
    rd_ready = 1'b1; wait_done(0);
    chk_window("single", 4, 1);

    // Clamp: 10 + 12 trimmed to a 16-word window
    start(10, 12, 1); feed(12); trig(); feed(6);
    rd_ready = 1'b1; wait_done(0);
    chk_window("clamp", 3, 16);
    chk("clamp_trig_addr", trig_addr, 12);

    // Random backpressure
    start(5, 7, 1); feed(8); trig(); feed(7);
    wait_done(1);
    chk_window("bp", 4, 12);

    // Arm together with mem_reset is discarded
    pre_len = AW'(2); post_len = AW'(2);
    cap_arm = 1'b1; mem_reset = 1'b1; tick();
    cap_arm = 1'b0; mem_reset = 1'b0; tick();
    chk("arm_vs_reset_busy", cap_busy, 0);

    // mem_reset in POST, then a fresh capture
    start(3, 5, 1); feed(5); trig(); feed(2);
    mem_reset = 1'b1; mereg_datv = 1'b1; tick();
    mem_reset = 1'b0; mereg_datv = 1'b0; tick();
    chk("post_reset_busy", cap_busy, 0);
    chk("post_reset_words", got.size(), 0);
    start(2, 3, 50); feed(4); trig(); feed(3);
    rd_ready = 1'b1; wait_done(0);
    chk_window("rearm", 52, 5);

    // mem_reset mid-readout: two words delivered, no cap_done
    start(4, 4, 1); feed(6); trig(); feed(4);
    rd_ready = 1'b1;
    repeat (4) tick();
    rd_ready = 1'b0; mem_reset = 1'b1; tick();
    mem_reset = 1'b0;
    repeat (3) tick();
    chk_window("midread", 3, 2);
    chk("midread_valid", rd_valid, 0);

    // Trigger during PRE is ignored; the later one defines the window
    start(4, 3, 1); feed(2); trig(); feed(3); trig(); feed(3);
    rd_ready = 1'b1; wait_done(0);
    chk_window("pre_trig", 2, 7);
    chk("pre_trig_addr", trig_addr, 5);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
